// File: rtl/elem_stream_sr_pkg.sv
// elem_stream_sr_pkg: shared definitions for the element shift buffer.
//   - default element width and depth for the top-level parameters
//   - decoded per-cycle operation type used by the next-state logic
package elem_stream_sr_pkg;

    localparam int unsigned ELEM_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 4;

    // One operation wins each cycle; streaming covers push, pop, both or neither.
    typedef enum logic [1:0] {
        OpFlush  = 2'd0,
        OpLoad   = 2'd1,
        OpStream = 2'd2
    } op_e;

endpackage

// File: rtl/elem_stream_sr.sv
// elem_stream_sr: parametrised element shift buffer.
// Holds up to DEPTH elements of ELEM_W bits. Loaded in parallel (load_*) or one
// element at a time (in_*), drained one element per cycle from slot 0 (out_*).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all contents this cycle
//   msb_first         parallel load order (1: highest element leaves first)
//   load_valid/ready  parallel word handshake, load_data holds DEPTH elements
//   in_valid/ready    serial element handshake, in_elem
//   out_valid/ready   head element handshake, out_elem
//   count/full/empty  occupancy status
module elem_stream_sr
    import elem_stream_sr_pkg::*;
#(
    parameter int unsigned ELEM_W = ELEM_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    msb_first,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DEPTH*ELEM_W-1:0] load_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ELEM_W-1:0]       in_elem,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ELEM_W-1:0]       out_elem,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty
);

    logic [ELEM_W-1:0] slots_q [DEPTH];
    logic [ELEM_W-1:0] slots_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic              pop;
    logic              push;
    logic              load;
    logic [CNT_W-1:0]  wr_idx;
    op_e               op;

    // Status and handshakes
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign out_valid  = !empty;
    assign out_elem   = slots_q[0];
    assign count      = count_q;
    assign load_ready = empty && !flush;
    // A load offered into an empty buffer takes priority over a serial push.
    assign in_ready   = (!full || out_ready) && !flush && !(load_valid && empty);

    assign pop  = out_valid && out_ready;
    assign push = in_valid && in_ready;
    assign load = load_valid && load_ready;

    // Push lands just past the surviving contents after any same-cycle pop.
    assign wr_idx = count_q - CNT_W'(pop);

    always_comb begin
        if (flush) begin
            op = OpFlush;
        end else if (load) begin
            op = OpLoad;
        end else begin
            op = OpStream;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            slots_d[k] = slots_q[k];
        end
        count_d = count_q;

        unique case (op)
            OpFlush: begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    slots_d[k] = '0;
                end
                count_d = '0;
            end
            OpLoad: begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    if (msb_first) begin
                        slots_d[k] = load_data[(int'(DEPTH) - 1 - k) * int'(ELEM_W) +: ELEM_W];
                    end else begin
                        slots_d[k] = load_data[k * int'(ELEM_W) +: ELEM_W];
                    end
                end
                count_d = CNT_W'(DEPTH);
            end
            default: begin
                if (pop) begin
                    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                        slots_d[k] = slots_q[k + 1];
                    end
                    slots_d[DEPTH-1] = '0;
                end
                if (push) begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        if (wr_idx == CNT_W'(k)) begin
                            slots_d[k] = in_elem;
                        end
                    end
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slots_q[k] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slots_q[k] <= slots_d[k];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_elem_stream_sr.sv
// tb_elem_stream_sr: directed self-checking bench for elem_stream_sr (ELEM_W=8, DEPTH=4).
module tb_elem_stream_sr;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        msb_first;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_elem;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_elem;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elem_stream_sr #(
        .ELEM_W(8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .msb_first (msb_first),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_elem   (in_elem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_elem  (out_elem),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check head element and occupancy together.
    task automatic chk_head(input string tag, input logic [7:0] e, input logic [2:0] c);
        chk({tag, "_elem"}, 32'(out_elem), 32'(e));
        chk({tag, "_count"}, 32'(count), 32'(c));
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        msb_first  = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        in_valid   = 1'b0;
        in_elem    = '0;
        out_ready  = 1'b0;

        // Reset / idle
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_elem", 32'(out_elem), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        tick();

        // LSB-first serialise
        load_data  = 32'hDDCC_BBAA;
        msb_first  = 1'b0;
        load_valid = 1'b1;
        out_ready  = 1'b1;
        #1;
        chk("lsb_load_ready", 32'(load_ready), 1);
        tick();
        load_valid = 1'b0;
        chk_head("lsb0", 8'hAA, 3'd4);
        chk("lsb0_full", 32'(full), 1);
        chk("lsb0_load_ready", 32'(load_ready), 0);
        tick();
        chk_head("lsb1", 8'hBB, 3'd3);
        tick();
        chk_head("lsb2", 8'hCC, 3'd2);
        tick();
        chk_head("lsb3", 8'hDD, 3'd1);
        tick();
        chk("lsb_end_empty", 32'(empty), 1);
        chk("lsb_end_valid", 32'(out_valid), 0);
        chk("lsb_end_load_ready", 32'(load_ready), 1);

        // MSB-first with backpressure
        out_ready  = 1'b0;
        msb_first  = 1'b1;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        msb_first  = 1'b0;
        chk_head("msb_hold0", 8'hDD, 3'd4);
        tick();
        chk_head("msb_hold1", 8'hDD, 3'd4);
        tick();
        chk_head("msb_hold2", 8'hDD, 3'd4);
        out_ready = 1'b1;
        tick();
        chk_head("msb1", 8'hCC, 3'd3);
        tick();
        chk_head("msb2", 8'hBB, 3'd2);
        tick();
        chk_head("msb3", 8'hAA, 3'd1);
        tick();
        chk("msb_end_empty", 32'(empty), 1);

        // Stream passthrough, one-cycle latency, count stays 1
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_elem = 8'(8'h11 + i);
            #1;
            chk("pass_in_ready", 32'(in_ready), 1);
            tick();
            chk_head("pass", 8'(8'h11 + i), 3'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("pass_end_empty", 32'(empty), 1);

        // Fill with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_elem = 8'(8'h11 + i);
            #1;
            chk("fill_in_ready", 32'(in_ready), 1);
            tick();
        end
        chk("fill_in_ready_low", 32'(in_ready), 0);
        chk("fill_full", 32'(full), 1);
        chk_head("fill", 8'h11, 3'd4);
        in_elem = 8'h20;
        tick();
        chk_head("fill_refused", 8'h11, 3'd4);

        // Full push + pop
        in_elem   = 8'h15;
        out_ready = 1'b1;
        #1;
        chk("pp_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk_head("pp0", 8'h12, 3'd4);
        tick();
        chk_head("pp1", 8'h13, 3'd3);
        tick();
        chk_head("pp2", 8'h14, 3'd2);
        tick();
        chk_head("pp3", 8'h15, 3'd1);
        tick();
        chk("pp_end_empty", 32'(empty), 1);

        // Contention: load wins over push into empty buffer
        out_ready  = 1'b0;
        load_data  = 32'h4433_2211;
        load_valid = 1'b1;
        in_valid   = 1'b1;
        in_elem    = 8'h99;
        #1;
        chk("cont_in_ready", 32'(in_ready), 0);
        chk("cont_load_ready", 32'(load_ready), 1);
        tick();
        load_valid = 1'b0;
        in_valid   = 1'b0;
        chk_head("cont_load", 8'h11, 3'd4);

        // Flush after two pops
        out_ready = 1'b1;
        tick();
        chk_head("fl_pop1", 8'h22, 3'd3);
        tick();
        chk_head("fl_pop2", 8'h33, 3'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_elem  = 8'h77;
        #1;
        chk("fl_in_ready", 32'(in_ready), 0);
        chk("fl_load_ready", 32'(load_ready), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_head("fl_after", 8'h00, 3'd0);
        chk("fl_out_valid", 32'(out_valid), 0);
        tick();
        chk("fl_still_empty", 32'(empty), 1);

        // Reset mid-drain
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        chk_head("rd_pre", 8'h33, 3'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_head("rd_after", 8'h00, 3'd0);
        chk("rd_out_valid", 32'(out_valid), 0);
        chk("rd_load_ready", 32'(load_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
